// File: rtl/prefix_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prefix_adder_pkg
// Brief    : Shared types and helpers for the pipelined Sklansky prefix adder.
// Revision : 1.0 - initial release
// ============================================================================
package prefix_adder_pkg;

  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

  // Left operand is the more significant group.
  function automatic pg_t pg_combine(input pg_t l, input pg_t r);
    pg_t res;
    res.g = l.g | (l.p & r.g);
    res.p = l.p & r.p;
    return res;
  endfunction

  function automatic int prefix_levels(input int width);
    return $clog2(width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/prefix_adder_row.sv
`default_nettype none
// ============================================================================
// Module   : prefix_adder_row
// Brief    : One registered Sklansky prefix level with valid and a/b bypass.
// Revision : 1.0 - initial release
// ============================================================================
module prefix_adder_row
  import prefix_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LEVEL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             valid_prev,
  input  pg_t  [WIDTH-1:0] pg_prev,
  input  logic [WIDTH-1:0] a_prev,
  input  logic [WIDTH-1:0] b_prev,
  output logic             valid,
  output pg_t  [WIDTH-1:0] pg,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b
);

  localparam int SPAN = 1 << (LEVEL - 1);

  pg_t  [WIDTH-1:0] w_pg;
  pg_t  [WIDTH-1:0] r_pg;
  logic             r_valid;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;

  // Index j is carry position j-1; j=0 holds the carry-in slot.
  for (genvar j = 0; j < WIDTH; j++) begin : g_pos
    if (((j / SPAN) % 2) == 1) begin : g_combine
      localparam int SRC = (j / SPAN) * SPAN - 1;
      assign w_pg[j] = pg_combine(pg_prev[j], pg_prev[SRC]);
    end else begin : g_pass
      assign w_pg[j] = pg_prev[j];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_pg    <= '0;
      r_a     <= '0;
      r_b     <= '0;
    end else if (en) begin
      r_valid <= valid_prev;
      r_pg    <= w_pg;
      r_a     <= a_prev;
      r_b     <= b_prev;
    end
  end

  assign valid = r_valid;
  assign pg    = r_pg;
  assign a     = r_a;
  assign b     = r_b;

endmodule
`default_nettype wire

// File: rtl/prefix_adder_pipe_hs.sv
`default_nettype none
// ============================================================================
// Module   : prefix_adder_pipe_hs
// Brief    : Pipelined Sklansky adder (s = a + b + cin) with valid/ready flow.
//            Define PREFIX_ADDER_SUB_EN to add the sub port (a - b).
// Revision : 1.0 - initial release
// ============================================================================
module prefix_adder_pipe_hs
  import prefix_adder_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PREFIX_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int LOG2W = prefix_levels(WIDTH);
  localparam int LAT   = LOG2W + 2;
  localparam int NSTG  = LAT - 1;

  logic             w_adv;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;
  pg_t  [WIDTH-1:0] w_pg0;

  logic             w_vld    [NSTG];
  pg_t  [WIDTH-1:0] w_stg_pg [NSTG];
  logic [WIDTH-1:0] w_stg_a  [NSTG];
  logic [WIDTH-1:0] w_stg_b  [NSTG];

  logic             r_vld0;
  pg_t  [WIDTH-1:0] r_pg0;
  logic [WIDTH-1:0] r_a0;
  logic [WIDTH-1:0] r_b0;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;

  assign w_adv    = !r_out_valid || out_ready;
  assign in_ready = w_adv;

`ifdef PREFIX_ADDER_SUB_EN
  assign w_b_eff   = b ^ {WIDTH{sub}};
  assign w_cin_eff = cin | sub;
`else
  assign w_b_eff   = b;
  assign w_cin_eff = cin;
`endif

  assign w_pg0[0] = '{p: 1'b0, g: w_cin_eff};
  for (genvar j = 1; j < WIDTH; j++) begin : g_pg0
    assign w_pg0[j] = '{p: a[j-1] | w_b_eff[j-1], g: a[j-1] & w_b_eff[j-1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld0 <= 1'b0;
      r_pg0  <= '0;
      r_a0   <= '0;
      r_b0   <= '0;
    end else if (w_adv) begin
      r_vld0 <= in_valid;
      r_pg0  <= w_pg0;
      r_a0   <= a;
      r_b0   <= w_b_eff;
    end
  end

  assign w_vld[0]    = r_vld0;
  assign w_stg_pg[0] = r_pg0;
  assign w_stg_a[0]  = r_a0;
  assign w_stg_b[0]  = r_b0;

  for (genvar k = 1; k <= LOG2W; k++) begin : g_row
    prefix_adder_row #(
      .WIDTH (WIDTH),
      .LEVEL (k)
    ) u_row (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (w_adv),
      .valid_prev (w_vld[k-1]),
      .pg_prev    (w_stg_pg[k-1]),
      .a_prev     (w_stg_a[k-1]),
      .b_prev     (w_stg_b[k-1]),
      .valid      (w_vld[k]),
      .pg         (w_stg_pg[k]),
      .a          (w_stg_a[k]),
      .b          (w_stg_b[k])
    );
  end

  pg_t  [WIDTH-1:0] w_fin;
  logic [WIDTH-1:0] w_carry;
  logic [WIDTH-1:0] w_unused_p;
  logic [WIDTH-1:0] w_fa;
  logic [WIDTH-1:0] w_fb;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;

  assign w_fin = w_stg_pg[LOG2W];
  assign w_fa  = w_stg_a[LOG2W];
  assign w_fb  = w_stg_b[LOG2W];

  // Every final group reaches the carry-in slot (P=0), so final P is always 0.
  for (genvar j = 0; j < WIDTH; j++) begin : g_carry
    assign w_carry[j]    = w_fin[j].g;
    assign w_unused_p[j] = w_fin[j].p;
  end

  assign w_sum  = w_fa ^ w_fb ^ w_carry;
  assign w_cout = (w_fa[WIDTH-1] & w_fb[WIDTH-1])
                | (w_fin[WIDTH-1].g & (w_fa[WIDTH-1] | w_fb[WIDTH-1]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_s         <= '0;
      r_cout      <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= w_vld[LOG2W];
      r_s         <= w_sum;
      r_cout      <= w_cout;
    end
  end

  assign out_valid = r_out_valid;
  assign s         = r_s;
  assign cout      = r_cout;

endmodule
`default_nettype wire
